// File: rtl/regfile_pkg.sv
// Shared register-file constants and the architectural register address type,
// used by decode, writeback and the register file itself.
package regfile_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int AW_DEF   = $clog2(NREG_DEF);

  typedef logic [AW_DEF-1:0] reg_adr_t;

  function automatic logic is_zero_reg(input reg_adr_t adr);
    return adr == '0;
  endfunction

endpackage

// File: rtl/regfile_scoreboard_sb.sv
// Pending-producer scoreboard: one bit per architectural register, set on issue,
// cleared by writeback or flush. Bit 0 is hard-wired clear.
module regfile_scoreboard_sb #(
  parameter  int NREG = 32,
  localparam int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            issue_valid_i,
  input  logic [AW-1:0]   issue_adr_i,
  input  logic            flush_i,
  input  logic [NREG-1:0] wr_clr_i,
  output logic [NREG-1:0] pend_o
);

  logic [NREG-1:0] pend_q;
  logic [NREG-1:0] pend_d;

  // Set after clear so a same-cycle issue marks the new producer outstanding.
  always_comb begin
    pend_d = pend_q & ~wr_clr_i;
    if (issue_valid_i) pend_d[issue_adr_i] = 1'b1;
    if (flush_i)       pend_d = '0;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pend_q <= '0;
    else          pend_q <= pend_d;
  end

  assign pend_o = pend_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with PC register and pending-write scoreboard.
// Optional write-to-read forwarding is compiled in with REGFILE_BYPASS_EN.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int XLEN = XLEN_DEF,
  parameter  int NREG = NREG_DEF,
  parameter  int NRD  = 2,
  parameter  int NWR  = 2,
  localparam int AW   = $clog2(NREG)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [XLEN-1:0]          PC_INIT,
  input  logic [NRD-1:0][AW-1:0]   RADR_SD,
  output logic [NRD-1:0][XLEN-1:0] RDATA_SR,
  output logic [NRD-1:0]           RBUSY_SR,
  input  logic [NWR-1:0][AW-1:0]   WADR_SW,
  input  logic [NWR-1:0][XLEN-1:0] WDATA_SW,
  input  logic [NWR-1:0]           WENABLE_SW,
  input  logic                     ISSUE_VALID_SD,
  input  logic [AW-1:0]            ISSUE_ADR_SD,
  input  logic                     FLUSH_SD,
  input  logic [XLEN-1:0]          WRITE_PC_SD,
  input  logic                     WRITE_PC_ENABLE_SD,
  output logic [XLEN-1:0]          READ_PC_SR,
  output logic [NREG-1:0]          PEND_SR
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [XLEN-1:0] pc_q;
  logic [NREG-1:0] wr_hit;
  logic [NREG-1:0] pend;

  // Later ports overwrite earlier ones, so the highest index wins a collision.
  always_comb begin
    regs_d = regs_q;
    wr_hit = '0;
    for (int i = 0; i < NWR; i++) begin
      if (WENABLE_SW[i] && WADR_SW[i] != '0) begin
        regs_d[WADR_SW[i]] = WDATA_SW[i];
        wr_hit[WADR_SW[i]] = 1'b1;
      end
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NREG; r++) regs_q[r] <= '0;
      pc_q <= PC_INIT;
    end else begin
      regs_q <= regs_d;
      if (WRITE_PC_ENABLE_SD) pc_q <= WRITE_PC_SD;
    end
  end

  regfile_scoreboard_sb #(.NREG(NREG)) u_sb (
    .clk           (clk),
    .reset_n       (reset_n),
    .issue_valid_i (ISSUE_VALID_SD),
    .issue_adr_i   (ISSUE_ADR_SD),
    .flush_i       (FLUSH_SD),
    .wr_clr_i      (wr_hit),
    .pend_o        (pend)
  );

  always_comb begin
    RDATA_SR = '0;
    RBUSY_SR = '0;
    for (int j = 0; j < NRD; j++) begin
      RDATA_SR[j] = regs_q[RADR_SD[j]];
      RBUSY_SR[j] = pend[RADR_SD[j]];
`ifdef REGFILE_BYPASS_EN
      for (int i = 0; i < NWR; i++) begin
        if (WENABLE_SW[i] && WADR_SW[i] == RADR_SD[j] && RADR_SD[j] != '0) begin
          RDATA_SR[j] = WDATA_SW[i];
          RBUSY_SR[j] = ISSUE_VALID_SD && (ISSUE_ADR_SD == RADR_SD[j]);
        end
      end
`endif
    end
  end

  assign READ_PC_SR = pc_q;
  assign PEND_SR    = pend;

endmodule
